muldiv_sequencer: RTL and testbench

//   Multi-cycle controller for MULT/MULTU/DIV/DIVU.

---
 rtl/muldiv_pkg.sv | 12 +
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 104 ++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and sizing for the multiply/divide sequencer
package muldiv_pkg;
  localparam int MULDIV_W = 32;
  localparam int CNT_W = $clog2(MULDIV_W);
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring shift-subtract (divide) iteration
//   div_i  : 1 selects divide, 0 selects multiply
//   acc_i  : upper partial product / partial remainder
//   opr_i  : remaining multiplier bits / dividend bits becoming quotient
//   m_i    : multiplicand / divisor magnitude
//   acc_o, opr_o : register values after this iteration
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] opr_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] opr_o
);
  logic [WIDTH:0] sum, sh, diff;
  logic ge;
  // The partial remainder is always below the divisor, so sh-m fits in WIDTH+1
  // bits and its top bit is the borrow.
  always_comb begin
    sum = {1'b0, acc_i} + (opr_i[0] ? {1'b0, m_i} : '0);
    sh = {acc_i, opr_i[WIDTH-1]};
    diff = sh - {1'b0, m_i};
    ge = ~diff[WIDTH];
    acc_o = div_i ? (ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0]) : sum[WIDTH:1];
    opr_o = div_i ? {opr_i[WIDTH-2:0], ge} : {sum[0], opr_i[WIDTH-1:1]};
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU controller writing {Hi,Lo} and stalling the PC
//   Clk, Rst (sync, active-high)
//   Start, Op, A, B        : request, sampled only in IDLE
//   Busy                   : state != IDLE (registered)
//   Stall                  : (Start & IDLE) | CALC | FIX (combinational)
//   HiLoEn, HiLoWrite      : one-cycle {Hi,Lo} write in DONE
//   DivByZero              : pulses with HiLoEn for a divide by zero
// Optional macro MULDIV_EARLY_OUT_EN: multiplies leave CALC once the remaining
// multiplier bits are all zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Stall,
  output logic               HiLoEn,
  output logic [2*WIDTH-1:0] HiLoWrite,
  output logic               DivByZero
);
  state_e state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, opr_q, opr_d, m_q, m_d, acc_n, opr_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;
  logic busy_q, en_q, en_d, dbz_q, dbz_d;
  logic [2*WIDTH-1:0] hilo_q, hilo_d;
  op_e op_w;
  logic is_div, a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  assign op_w = op_e'(Op);
  assign is_div = (op_w == OP_DIV) || (op_w == OP_DIVU);
  assign a_neg = ((op_w == OP_MULT) || (op_w == OP_DIV)) & A[WIDTH-1];
  assign b_neg = ((op_w == OP_MULT) || (op_w == OP_DIV)) & B[WIDTH-1];
  assign abs_a = a_neg ? -A : A;
  assign abs_b = b_neg ? -B : B;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i(div_q),
    .acc_i(acc_q),
    .opr_i(opr_q),
    .m_i  (m_q),
    .acc_o(acc_n),
    .opr_o(opr_n)
  );
  // Multiply keeps the multiplier in opr and the multiplicand in m; divide keeps
  // the dividend in opr (it becomes the quotient) and the divisor in m.
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    opr_d = opr_q;
    m_d = m_q;
    cnt_d = cnt_q;
    div_d = div_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    hilo_d = hilo_q;
    en_d = 1'b0;
    dbz_d = 1'b0;
    case (state_q)
      S_IDLE: if (Start) begin
        acc_d = '0;
        opr_d = is_div ? abs_a : abs_b;
        m_d = is_div ? abs_b : abs_a;
        cnt_d = CNT_W'(WIDTH - 1);
        div_d = is_div;
        neg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        state_d = S_CALC;
        if (is_div && B == '0) begin
          state_d = S_DONE;
          hilo_d = {A, {WIDTH{1'b1}}};
          en_d = 1'b1;
          dbz_d = 1'b1;
        end
      end
      S_CALC: begin
        acc_d = acc_n;
        opr_d = opr_n;
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? S_FIX : S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
        // The low cnt_q bits of opr_n are the multiplier bits still to be consumed;
        // when they are zero the rest of the work is a plain right shift.
        if (!div_q && (opr_n & ~({WIDTH{1'b1}} << cnt_q)) == '0) begin
          {acc_d, opr_d} = {acc_n, opr_n} >> cnt_q;
          state_d = S_FIX;
        end
`endif
      end
      S_FIX: begin
        state_d = S_DONE;
        en_d = 1'b1;
        hilo_d = div_q ? {rneg_q ? -acc_q : acc_q, neg_q ? -opr_q : opr_q}
                       : (neg_q ? -{acc_q, opr_q} : {acc_q, opr_q});
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      acc_q <= '0;
      opr_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      busy_q <= 1'b0;
      en_q <= 1'b0;
      dbz_q <= 1'b0;
      hilo_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      opr_q <= opr_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      busy_q <= state_d != S_IDLE;
      en_q <= en_d;
      dbz_q <= dbz_d;
      hilo_q <= hilo_d;
    end
  end
  assign Stall = (Start && state_q == S_IDLE) || state_q == S_CALC || state_q == S_FIX;
  assign Busy = busy_q;
  assign HiLoEn = en_q;
  assign HiLoWrite = hilo_q;
  assign DivByZero = dbz_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic Clk = 1'b0, Rst = 1'b1, Start = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [31:0] A = '0, B = '0;
  logic Busy, Stall, HiLoEn, DivByZero;
  logic [63:0] HiLoWrite;
  int n_chk = 0, n_pass = 0;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  muldiv_sequencer #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .Busy(Busy), .Stall(Stall), .HiLoEn(HiLoEn), .HiLoWrite(HiLoWrite), .DivByZero(DivByZero)
  );
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // HiLoEn cycle for a multiply: WIDTH+2, or (CALC cycles)+2 with early out
  function automatic int mul_lat(input logic [31:0] b, input bit sgn);
    logic [31:0] m;
    int n;
    m = (sgn && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return EARLY ? n + 2 : 34;
  endfunction
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_hilo, input int exp_lat, input bit exp_dbz,
                        input int rs1, input int rs2, input int rst_cyc);
    int pulses, lat, gaps;
    logic [63:0] got;
    logic got_dbz;
    pulses = 0; lat = -1; gaps = 0; got = '0; got_dbz = 1'b0;
    @(posedge Clk); #1;
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    check({tag, "/stall0"}, 64'(Stall), 64'd1);
    for (int c = 1; c <= 50; c++) begin
      @(posedge Clk); #1;
      Start = (c == rs1) || (c == rs2);
      A = Start ? 32'd9 : $urandom;
      B = Start ? 32'd9 : $urandom;
      if (!Start) Op = 2'($urandom);
      Rst = (c == rst_cyc);
      @(negedge Clk);
      if (HiLoEn) begin
        pulses++;
        if (lat < 0) begin
          lat = c; got = HiLoWrite; got_dbz = DivByZero;
          check({tag, "/busy_done"}, 64'(Busy), 64'd1);
          check({tag, "/stall_done"}, 64'(Stall), 64'd0);
        end
      end
      if (c < exp_lat && !Stall) gaps++;
      if (c == exp_lat + 1) check({tag, "/busy_after"}, 64'(Busy), 64'd0);
      if (c == rst_cyc + 1) begin
        check({tag, "/busy_rst"}, 64'(Busy), 64'd0);
        check({tag, "/stall_rst"}, 64'(Stall), 64'd0);
      end
    end
    Start = 1'b0; Rst = 1'b0;
    check({tag, "/pulses"}, 64'(pulses), (exp_lat > 0) ? 64'd1 : 64'd0);
    if (exp_lat > 0) begin
      check({tag, "/lat"}, 64'(lat), 64'(exp_lat));
      check({tag, "/hilo"}, got, exp_hilo);
      check({tag, "/dbz"}, 64'(got_dbz), 64'(exp_dbz));
      check({tag, "/stall_gaps"}, 64'(gaps), 64'd0);
    end
  endtask
  initial begin
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    check("rst/busy", 64'(Busy), 64'd0);
    check("rst/stall", 64'(Stall), 64'd0);
    check("rst/hiloen", 64'(HiLoEn), 64'd0);
    check("rst/dbz", 64'(DivByZero), 64'd0);
    check("rst/hilo", HiLoWrite, 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, mul_lat(32'd2, 1'b0), 1'b0, -1, -1, -1);
    run_op("mult_neg", 2'b00, 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB, mul_lat(32'd7, 1'b1), 1'b0, -1, -1, -1);
    run_op("mult_nn", 2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 64'd6, mul_lat(32'hFFFFFFFD, 1'b1), 1'b0, -1, -1, -1);
    run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 64'h40000000_00000000, mul_lat(32'h80000000, 1'b1), 1'b0, -1, -1, -1);
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34, 1'b0, -1, -1, -1);
    run_op("divu", 2'b11, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 34, 1'b0, -1, -1, -1);
    run_op("div_pn", 2'b10, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 1'b0, -1, -1, -1);
    run_op("divu_z", 2'b11, 32'd100, 32'd0, 64'h00000064_FFFFFFFF, 1, 1'b1, -1, -1, -1);
    run_op("div_z", 2'b10, 32'hFFFFFFFB, 32'd0, 64'hFFFFFFFB_FFFFFFFF, 1, 1'b1, -1, -1, -1);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 1'b0, -1, -1, -1);
    run_op("rst_abort", 2'b11, 32'd1234, 32'd5, 64'd0, -1, 1'b0, -1, -1, 10);
    run_op("multu_after", 2'b01, 32'd6, 32'd7, 64'd42, mul_lat(32'd7, 1'b0), 1'b0, -1, -1, -1);
    run_op("restart", 2'b01, 32'd3, 32'd5, 64'd15, mul_lat(32'd5, 1'b0), 1'b0, 5, mul_lat(32'd5, 1'b0), -1);
    run_op("multu_one", 2'b01, 32'd5, 32'd1, 64'd5, mul_lat(32'd1, 1'b0), 1'b0, -1, -1, -1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
